// File: rtl/imem_uart_loader.sv
// UART-fed instruction-memory loader: receives SYNC/LEN/DATA/CSUM frames and
// writes them byte-by-byte into imem. Optional inter-byte timeout: LOADER_TIMEOUT_EN.
module imem_uart_loader #(
  parameter int         WIDTH        = 32,
  parameter int         IMEM_DEPTH   = 4096,
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 1000000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             rx,
  output logic             insMemEn,
  output logic [WIDTH-1:0] insMemAddr,
  output logic [WIDTH-1:0] insMemData,
  output logic             cpuReset,
  output logic             loadDone,
  output logic             loadError
);

  localparam int          CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0] MAX_LEN = 17'(IMEM_DEPTH);

  if (CLKS_PER_BIT < 4 || TIMEOUT_CLKS < 1) begin : g_bad_param
    $error("imem_uart_loader: CLKS_PER_BIT must be >= 4 and TIMEOUT_CLKS >= 1");
  end

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR} state_t;

  // ---------------------------------------------------------------- UART RX
  logic             rx_meta, rx_sync, rx_prev;
  rx_state_t        rx_state, rx_state_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_byte;
  logic             rx_cnt_clr, shift_en, stop_sample;
  logic             byte_valid, frame_err;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    rx_state_next = rx_state;
    rx_cnt_clr    = 1'b0;
    shift_en      = 1'b0;
    stop_sample   = 1'b0;
    unique case (rx_state)
      RX_IDLE: if (rx_prev && !rx_sync) begin
        rx_state_next = RX_START;
        rx_cnt_clr    = 1'b1;
      end
      RX_START: if (rx_cnt == HALF_M1) begin
        rx_cnt_clr    = 1'b1;
        rx_state_next = rx_sync ? RX_IDLE : RX_BITS;  // high at mid-start = glitch
      end
      RX_BITS: if (rx_cnt == FULL_M1) begin
        rx_cnt_clr = 1'b1;
        shift_en   = 1'b1;
        if (bit_idx == 3'd7) rx_state_next = RX_STOP;
      end
      RX_STOP: if (rx_cnt == FULL_M1) begin
        rx_cnt_clr    = 1'b1;
        stop_sample   = 1'b1;
        rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_state_next;
      rx_cnt     <= (rx_cnt_clr || rx_state == RX_IDLE) ? '0 : rx_cnt + 1'b1;
      if (rx_state == RX_START)
        bit_idx <= '0;
      else if (shift_en)
        bit_idx <= bit_idx + 3'd1;
      if (shift_en) rx_byte <= {rx_sync, rx_byte[7:1]};
      byte_valid <= stop_sample &&  rx_sync;
      frame_err  <= stop_sample && !rx_sync;
    end
  end

  // ---------------------------------------------------------------- loader FSM
  state_t      state, state_next;
  logic [15:0] len, idx;
  logic [7:0]  csum;
  logic        in_frame, timeout;
  logic        start_frame, take_lo, take_hi, do_write, set_done, set_error;

  assign in_frame = (state == LEN_LO) || (state == LEN_HI) ||
                    (state == DATA)   || (state == CSUM);

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    to_cnt <= '0;
    else if (byte_valid || !in_frame) to_cnt <= '0;
    else                             to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = in_frame && !byte_valid && (to_cnt == TO_W'(TIMEOUT_CLKS - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    take_lo     = 1'b0;
    take_hi     = 1'b0;
    do_write    = 1'b0;
    set_done    = 1'b0;
    set_error   = 1'b0;
    unique case (state)
      IDLE, DONE, ERROR: if (byte_valid && rx_byte == SYNC_BYTE) begin
        state_next  = LEN_LO;
        start_frame = 1'b1;
      end
      LEN_LO: if (byte_valid) begin
        state_next = LEN_HI;
        take_lo    = 1'b1;
      end
      LEN_HI: if (byte_valid) begin
        take_hi = 1'b1;
        if ({1'b0, rx_byte, len[7:0]} > MAX_LEN) begin
          state_next = ERROR;
          set_error  = 1'b1;
        end else if ({rx_byte, len[7:0]} == 16'd0) begin
          state_next = CSUM;
        end else begin
          state_next = DATA;
        end
      end
      DATA: if (byte_valid) begin
        do_write = 1'b1;
        if (idx + 16'd1 == len) state_next = CSUM;
      end
      CSUM: if (byte_valid) begin
        if (rx_byte == csum) begin
          state_next = DONE;
          set_done   = 1'b1;
        end else begin
          state_next = ERROR;
          set_error  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // A bad stop bit or a stalled sender inside a frame aborts the load.
    if (in_frame && (frame_err || timeout)) begin
      state_next = ERROR;
      set_error  = 1'b1;
      do_write   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len        <= '0;
      idx        <= '0;
      csum       <= '0;
      insMemEn   <= 1'b0;
      insMemAddr <= '0;
      insMemData <= '0;
      cpuReset   <= 1'b1;
      loadDone   <= 1'b0;
      loadError  <= 1'b0;
    end else begin
      insMemEn <= do_write;
      if (start_frame) begin
        idx       <= '0;
        csum      <= '0;
        cpuReset  <= 1'b1;
        loadDone  <= 1'b0;
        loadError <= 1'b0;
      end
      if (take_lo) len[7:0]  <= rx_byte;
      if (take_hi) len[15:8] <= rx_byte;
      if (do_write) begin
        insMemAddr <= WIDTH'(idx);
        insMemData <= WIDTH'(rx_byte);
        csum       <= csum + rx_byte;
        idx        <= idx + 16'd1;
      end
      if (set_done) begin
        loadDone <= 1'b1;
        cpuReset <= 1'b0;
      end
      if (set_error) begin
        loadError <= 1'b1;
        cpuReset  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader: table of framed loads plus
// hand-written glitch, async-reset and (with LOADER_TIMEOUT_EN) timeout sequences.
module tb_imem_uart_loader;

  localparam int CPB = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rx;
  logic        insMemEn;
  logic [31:0] insMemAddr;
  logic [31:0] insMemData;
  logic        cpuReset;
  logic        loadDone;
  logic        loadError;

  imem_uart_loader #(
    .WIDTH       (32),
    .IMEM_DEPTH  (4096),
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CLKS(500)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx        (rx),
    .insMemEn  (insMemEn),
    .insMemAddr(insMemAddr),
    .insMemData(insMemData),
    .cpuReset  (cpuReset),
    .loadDone  (loadDone),
    .loadError (loadError)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Write log, sampled on the falling edge, one entry per cycle insMemEn is high.
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  always @(negedge clock) begin
    if (insMemEn) begin
      wr_addr_q.push_back(insMemAddr);
      wr_data_q.push_back(insMemData);
    end
  end

  typedef struct {
    string           name;
    int              nbytes;
    logic [0:9][7:0] bytes;
    int              bad_stop;    // index of the byte sent with stop=0, -1 none
    int              data_off;    // index of the first payload byte
    int              exp_writes;
    logic            exp_done;
    logic            exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clock) rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    clear_log();
    for (int j = 0; j < v.nbytes; j++)
      send_byte(v.bytes[j], (j == v.bad_stop) ? 1'b0 : 1'b1);
    repeat (8) @(negedge clock);
    check({v.name, " writes"}, 32'(wr_addr_q.size()), 32'(v.exp_writes));
    for (int k = 0; k < v.exp_writes; k++) begin
      if (k < wr_addr_q.size()) begin
        check($sformatf("%s addr%0d", v.name, k), wr_addr_q[k], 32'(k));
        check($sformatf("%s data%0d", v.name, k), wr_data_q[k], {24'b0, v.bytes[v.data_off + k]});
      end
    end
    check({v.name, " loadDone"},  32'(loadDone),  32'(v.exp_done));
    check({v.name, " loadError"}, 32'(loadError), 32'(v.exp_err));
    check({v.name, " cpuReset"},  32'(cpuReset),  32'(!v.exp_done));
  endtask

  initial begin
    vecs[0] = '{"good4", 8, {8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13, 16'h0},
                -1, 3, 4, 1'b1, 1'b0};
    vecs[1] = '{"badsum", 8, {8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14, 16'h0},
                -1, 3, 4, 1'b0, 1'b1};
    vecs[2] = '{"junk_lead", 7, {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h7F, 8'h7F, 24'h0},
                -1, 5, 1, 1'b1, 1'b0};
    vecs[3] = '{"len4097", 3, {8'hA5, 8'h01, 8'h10, 56'h0},
                -1, 3, 0, 1'b0, 1'b1};
    vecs[4] = '{"after_len_err", 8, {8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13, 16'h0},
                -1, 3, 4, 1'b1, 1'b0};
    vecs[5] = '{"bad_stop", 5, {8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 40'h0},
                4, 3, 1, 1'b0, 1'b1};
    vecs[6] = '{"sync_as_data", 5, {8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 40'h0},
                -1, 3, 1, 1'b1, 1'b0};
    vecs[7] = '{"len0_ok", 4, {8'hA5, 8'h00, 8'h00, 8'h00, 48'h0},
                -1, 3, 0, 1'b1, 1'b0};
    vecs[8] = '{"len0_bad", 4, {8'hA5, 8'h00, 8'h00, 8'h01, 48'h0},
                -1, 3, 0, 1'b0, 1'b1};

    // Reset state
    rx      = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst insMemEn",   32'(insMemEn),  32'd0);
    check("rst insMemAddr", insMemAddr,     32'd0);
    check("rst insMemData", insMemData,     32'd0);
    check("rst cpuReset",   32'(cpuReset),  32'd1);
    check("rst loadDone",   32'(loadDone),  32'd0);
    check("rst loadError",  32'(loadError), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Two-cycle low glitches, one in IDLE and one between frame bytes.
    clear_log();
    @(negedge clock) rx = 1'b0;
    repeat (2) @(negedge clock);
    rx = 1'b1;
    repeat (40) @(negedge clock);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    @(negedge clock) rx = 1'b0;
    repeat (2) @(negedge clock);
    rx = 1'b1;
    repeat (40) @(negedge clock);
    send_byte(8'h7F, 1'b1);
    send_byte(8'h7F, 1'b1);
    repeat (8) @(negedge clock);
    check("glitch writes", 32'(wr_addr_q.size()), 32'd1);
    if (wr_data_q.size() > 0) check("glitch data0", wr_data_q[0], 32'h7F);
    check("glitch loadDone", 32'(loadDone), 32'd1);

    // Length exactly IMEM_DEPTH is accepted; reset_n aborts during data byte 2.
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    repeat (8) @(negedge clock);
    check("len4096 loadError", 32'(loadError), 32'd0);
    check("len4096 cpuReset",  32'(cpuReset),  32'd1);
    send_byte(8'h13, 1'b1);
    repeat (4) @(negedge clock);
    check("midrst writes", 32'(wr_addr_q.size()), 32'd1);
    check("midrst data before", insMemData, 32'h13);
    @(negedge clock) rx = 1'b0;
    repeat (3 * CPB) @(negedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("midrst insMemEn",   32'(insMemEn),  32'd0);
    check("midrst insMemData", insMemData,     32'd0);
    check("midrst insMemAddr", insMemAddr,     32'd0);
    check("midrst cpuReset",   32'(cpuReset),  32'd1);
    check("midrst loadDone",   32'(loadDone),  32'd0);
    check("midrst loadError",  32'(loadError), 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    run_vec(vecs[0]);

`ifdef LOADER_TIMEOUT_EN
    // Sender stalls after the length; error should appear ~500 cycles after the last byte.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (480) @(negedge clock);
    check("timeout early", 32'(loadError), 32'd0);
    repeat (30) @(negedge clock);
    check("timeout fired", 32'(loadError), 32'd1);
    check("timeout cpuReset", 32'(cpuReset), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
